// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side controller for the single-clock FIFO (registered read port with
// one cycle of read latency). It pops words with rd_en and presents them in
// FIFO order on a valid/ready stream. A two-entry output buffer (head + skid)
// with credit accounting means the block never overreads the FIFO and still
// sustains one word per cycle. Delivered words are counted for debug.
//
// Optional feature: define FIFO_RD_BURST_EN to start reading only once the
// FIFO level reaches BURST_THR and to end each burst when the FIFO runs empty.
// With the macro undefined, reading starts on the first available word and
// RUN persists through transient empties until enable drops.
//
// Ports:
//   clk           rising-edge clock, shared with the FIFO
//   rst           asynchronous active-low reset
//   enable        permits new FIFO reads while high
//   buf_out       FIFO read data, valid the cycle after rd_en
//   buf_empty     FIFO empty flag
//   fifo_counter  FIFO occupancy
//   rd_en         FIFO pop request, one word per asserted cycle
//   m_data        stream data (head of the output buffer)
//   m_valid       m_data valid
//   m_ready       consumer accepts when m_valid && m_ready at a rising edge
//   rd_count      words accepted downstream (wraps at 16 bits)
//   busy          high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int BURST_THR = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  input  logic [CNT_W-1:0]  fifo_counter,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       rd_count,
  output logic              busy
);

  // state | meaning
  // ------+-------------------------------------------------------------
  // IDLE  | nothing buffered or in flight, no reads issued
  // RUN   | issuing reads whenever FIFO has data and a buffer credit exists
  // STOP  | no new reads; in-flight word is captured, buffer drains
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] THR = CNT_W'(BURST_THR);

  state_e state_q, state_d;

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [15:0]       rd_count_q, rd_count_d;

  logic       pop;
  logic [2:0] credit_used;
  logic       start_cond;
  logic       run_exit;
  logic       drained;

  assign pop = m_valid && m_ready;

  // Words already owned by the buffer once this cycle's pop is accounted for.
  // Reading only while this is below 2 guarantees the in-flight word always
  // has a slot when it lands next cycle.
  assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign drained = (occ_q == 2'd0) && !inflight_q;

`ifdef FIFO_RD_BURST_EN
  assign start_cond = enable && (fifo_counter >= THR);
  assign run_exit   = !enable || buf_empty;
`else
  assign start_cond = enable && !buf_empty;
  assign run_exit   = !enable;

  logic unused_cnt;
  assign unused_cnt = ^{fifo_counter, THR};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_cond) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (run_exit) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Re-arming straight from STOP avoids a dead IDLE cycle when enable
        // returns before the buffer has drained.
        if (start_cond) begin
          state_d = RUN;
        end else if (drained) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_en = 1'b0;
        busy  = 1'b0;
      end
      RUN: begin
        rd_en = !buf_empty && (credit_used < 3'd2);
        busy  = 1'b1;
      end
      STOP: begin
        rd_en = 1'b0;
        busy  = 1'b1;
      end
      default: begin
        rd_en = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output buffer and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    inflight_d = rd_en;
    rd_count_d = rd_count_q;

    if (pop) begin
      rd_count_d = rd_count_q + 16'd1;
      if (occ_q == 2'd2) begin
        head_d = skid_q;
      end
    end

    // The returning word goes to whichever slot is the tail after this
    // cycle's pop, so ordering stays strictly FIFO.
    if (inflight_q) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
        head_d = buf_out;
      end else begin
        skid_d = buf_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      rd_count_q <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign rd_count = rd_count_q;

endmodule
